// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer result display:
// FSM state encoding, segment constants and the BCD-digit-to-segment decoder.
package reaction_pkg;

  localparam int unsigned BIN_W               = 16;
  localparam int unsigned BCD_DIGITS          = 4;
  localparam int unsigned BCD_W               = 4 * BCD_DIGITS;
  localparam int unsigned SEG_W               = 7;
  localparam int unsigned CNT_W               = $clog2(BIN_W);
  localparam int unsigned MAX_DISPLAY_DEFAULT = 9999;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes render blank
  function automatic logic [SEG_W-1:0] digit_to_seg(input logic [3:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: 16 cycles from start to the final shift.
// done_c is high during the cycle whose clock edge performs that final shift.
module bin2bcd_serial
  import reaction_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [BIN_W-1:0] bin,
  output logic             done_c,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [BCD_W-1:0] adj_c;

  // Add-3 correction on every nibble that would overflow past 9 when doubled
  always_comb begin
    adj_c = bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign done_c = busy && (cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      bcd  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (abort) begin
        busy <= 1'b0;
      end else begin
        bcd <= {adj_c[BCD_W-2:0], sh[BIN_W-1]};
        sh  <= {sh[BIN_W-2:0], 1'b0};
        cnt <= cnt + CNT_W'(1);
        if (done_c) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/reaction_result_display.sv
// Result display for the reaction timer: captures the elapsed time, converts to BCD
// and scans a 4-digit active-low seven-segment display. Option: LEADING_ZERO_BLANK_EN.
module reaction_result_display
  import reaction_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned MAX_DISPLAY = MAX_DISPLAY_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             waiting_to_start,
  input  logic             show_result,
  input  logic [BIN_W-1:0] time_elapsed,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic [3:0]       an,
  output logic             bcd_valid,
  output logic             overflow
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t           state;
  logic             show_prev;
  logic [PRE_W-1:0] presc;
  logic [1:0]       idx;
  logic [BCD_W-1:0] bcd;

  logic             start_c;
  logic             abort_c;
  logic             done_c;
  logic             over_c;
  logic [BIN_W-1:0] capture_c;
  logic [3:0]       digit_c;
  logic [3:0]       anode_c;
  logic             lead_blank_c;

  assign start_c   = (state == IDLE) && show_result && !show_prev;
  assign abort_c   = (state == CONVERT) && !show_result;
  assign over_c    = time_elapsed > BIN_W'(MAX_DISPLAY);
  assign capture_c = over_c ? BIN_W'(MAX_DISPLAY) : time_elapsed;

  bin2bcd_serial u_bin2bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_c),
    .abort   (abort_c),
    .bin     (capture_c),
    .done_c  (done_c),
    .bcd     (bcd)
  );

  // Result FSM; a falling show_result always returns to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      show_prev <= 1'b0;
      bcd_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      show_prev <= show_result;
      case (state)
        IDLE: begin
          if (start_c) begin
            overflow  <= over_c;
            bcd_valid <= 1'b0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          if (!show_result) begin
            state <= IDLE;
          end else if (done_c) begin
            bcd_valid <= 1'b1;
            state     <= SHOW;
          end
        end
        SHOW: begin
          if (!show_result) begin
            bcd_valid <= 1'b0;
            overflow  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running digit scan
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  assign digit_c = bcd[{idx, 2'b00} +: 4];
  assign anode_c = ~(4'b0001 << idx);

`ifdef LEADING_ZERO_BLANK_EN
  // Slot is a leading zero when it and every higher digit are zero; ones digit always lit
  assign lead_blank_c = (idx != 2'd0) && ((bcd >> {idx, 2'b00}) == '0);
`else
  assign lead_blank_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
    end else begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
      dp  <= 1'b1;
      if (state == SHOW) begin
        if (!lead_blank_c) begin
          seg <= digit_to_seg(digit_c);
          an  <= anode_c;
        end
        dp <= !((idx == 2'd3) && overflow);
      end else if (waiting_to_start) begin
        seg <= SEG_DASH;
        an  <= anode_c;
      end
    end
  end

endmodule

// File: tb/tb_reaction_result_display.sv
// Self-checking bench for reaction_result_display (SCAN_DIV=4): hand sequences,
// a vector table and randomized traffic against a cycle-level arithmetic model.
module tb_reaction_result_display;

  localparam int unsigned SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        waiting = 1'b0;
  logic        show = 1'b0;
  logic [15:0] te = 16'd0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        bcd_valid;
  logic        overflow;

  int n_chk = 0;
  int n_fail = 0;

  reaction_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .waiting_to_start (waiting),
    .show_result      (show),
    .time_elapsed     (te),
    .seg              (seg),
    .dp               (dp),
    .an               (an),
    .bcd_valid        (bcd_valid),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int pow10 [4] = '{1, 10, 100, 1000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 converting, 2 showing; value kept as an integer
  int         m_phase = 0, m_cnt = 0, m_idx = 0, m_presc = 0, m_val = 0, m_digit;
  bit         m_ovf = 0, m_valid = 0, m_prev = 0, m_blank;
  logic [6:0] e_seg = 7'h7F;
  logic [3:0] e_an = 4'hF;
  logic       e_dp = 1'b1;
  logic [3:0] m_oh;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_cnt = 0; m_idx = 0; m_presc = 0; m_val = 0;
      m_ovf = 0; m_valid = 0; m_prev = 0;
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
    end else begin
      m_oh  = 4'b0001 << m_idx;
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
      if (m_phase == 2) begin
        m_digit = (m_val / pow10[m_idx]) % 10;
        m_blank = LZB && (m_idx != 0) && (m_val < pow10[m_idx]);
        if (!m_blank) begin
          e_seg = segtab[m_digit];
          e_an  = ~m_oh;
        end
        e_dp = !(m_idx == 3 && m_ovf);
      end else if (waiting) begin
        e_seg = 7'b0111111;
        e_an  = ~m_oh;
      end
      if (m_presc == SCAN_DIV - 1) begin
        m_presc = 0;
        m_idx   = (m_idx + 1) % 4;
      end else begin
        m_presc++;
      end
      case (m_phase)
        0: if (show && !m_prev) begin
             m_val   = (int'(te) > 9999) ? 9999 : int'(te);
             m_ovf   = int'(te) > 9999;
             m_valid = 0;
             m_cnt   = 0;
             m_phase = 1;
           end
        1: if (!show) m_phase = 0;
           else begin
             m_cnt++;
             if (m_cnt == 16) begin m_phase = 2; m_valid = 1; end
           end
        default: if (!show) begin m_phase = 0; m_valid = 0; m_ovf = 0; end
      endcase
      m_prev = show;
    end
  end

  always @(negedge clk) begin
    chk("model_seg", seg, e_seg);
    chk("model_an", an, e_an);
    chk("model_dp", dp, e_dp);
    chk("model_valid", bcd_valid, m_valid);
    chk("model_ovf", overflow, m_ovf);
  end

  task automatic rise_and_time(input logic [15:0] val, output int lat);
    show = 1'b0; waiting = 1'b0;
    repeat (3) @(negedge clk);
    te = val; show = 1'b1; lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bcd_valid && lat == 0) lat = k;
    end
  endtask

  task automatic check_slots(input logic [15:0] exp_bcd, input logic exp_ovf);
    logic [3:0] seen, oh, nib;
    logic [6:0] sseg [4];
    logic       sdp [4];
    logic       exp_seen;
    seen = 4'h0;
    for (int i = 0; i < 4; i++) begin sseg[i] = 7'h7F; sdp[i] = 1'b1; end
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        oh = 4'b0001 << i;
        if (an == ~oh) begin seen[i] = 1'b1; sseg[i] = seg; sdp[i] = dp; end
      end
    end
    for (int i = 0; i < 4; i++) begin
      nib = exp_bcd[4*i +: 4];
      exp_seen = !(LZB && i > 0 && (exp_bcd >> (4*i)) == 16'd0);
      chk("slot_seen", seen[i], exp_seen);
      if (exp_seen) begin
        chk("slot_seg", sseg[i], segtab[nib]);
        chk("slot_dp", sdp[i], (i == 3 && exp_ovf) ? 0 : 1);
      end
    end
  endtask

  typedef struct {
    logic [15:0] te;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;
  vec_t vec [9];

  initial begin
    int         lat, len;
    bit         found;
    logic [3:0] prev_an, oh, exp_an;

    vec[0] = '{16'd273,   16'h0273, 1'b0};
    vec[1] = '{16'd12345, 16'h9999, 1'b1};
    vec[2] = '{16'd0,     16'h0000, 1'b0};
    vec[3] = '{16'd9999,  16'h9999, 1'b0};
    vec[4] = '{16'd10000, 16'h9999, 1'b1};
    vec[5] = '{16'd65535, 16'h9999, 1'b1};
    vec[6] = '{16'd1,     16'h0001, 1'b0};
    vec[7] = '{16'd4095,  16'h4095, 1'b0};
    vec[8] = '{16'd1000,  16'h1000, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_an", an, 4'hF);
    chk("rst_dp", dp, 1'b1);
    chk("rst_valid", bcd_valid, 1'b0);
    reset_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("idle_seg", seg, 7'h7F);
      chk("idle_an", an, 4'hF);
      chk("idle_valid", bcd_valid, 1'b0);
    end

    // Dashes: each anode held SCAN_DIV cycles in order 0..3
    waiting = 1'b1; found = 0; prev_an = 4'hF;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev_an != 4'b1110) found = 1;
      prev_an = an;
    end
    chk("dash_sync", found, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      oh = 4'b0001 << (k / 4);
      exp_an = ~oh;
      chk("dash_an", an, exp_an);
      chk("dash_seg", seg, 7'b0111111);
    end

    // Vector table: latency, overflow and every digit slot
    for (int t = 0; t < 9; t++) begin
      rise_and_time(vec[t].te, lat);
      chk("latency", lat, 17);
      chk("vec_ovf", overflow, vec[t].ovf);
      te = 16'($urandom);
      check_slots(vec[t].bcd, vec[t].ovf);
    end

    // Abort mid-conversion, then a clean capture of zero
    show = 1'b0;
    repeat (3) @(negedge clk);
    te = 16'd500; show = 1'b1;
    repeat (5) @(negedge clk);
    show = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk("abort_valid", bcd_valid, 1'b0);
      chk("abort_an", an, 4'hF);
    end
    rise_and_time(16'd0, lat);
    chk("zero_latency", lat, 17);
    check_slots(16'h0000, 1'b0);

    // Asynchronous reset while showing an overflowed value
    rise_and_time(16'd12345, lat);
    chk("pre_rst_ovf", overflow, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_seg", seg, 7'h7F);
    chk("arst_an", an, 4'hF);
    chk("arst_dp", dp, 1'b1);
    chk("arst_valid", bcd_valid, 1'b0);
    chk("arst_ovf", overflow, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    show = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized traffic, checked cycle by cycle by the model
    for (int b = 0; b < 60; b++) begin
      case ($urandom % 4)
        0: te = 16'd9999;
        1: te = 16'd10000;
        2: te = 16'($urandom_range(0, 120));
        default: te = 16'($urandom);
      endcase
      show = 1'b1;
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        if ($urandom % 16 == 0) waiting = ~waiting;
        if ($urandom % 8 == 0) te = 16'($urandom);
      end
      show = 1'b0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_result_display.md
Name: reaction_result_display

Overview:
- Consumer end of the reaction-timer result interface.
- Takes the timer's 16-bit elapsed-millisecond count plus its waiting and result-ready status flags.
- Converts the count to four BCD digits with a serial double-dabble converter.
- Drives a 4-digit multiplexed seven-segment display (active-low segments and anodes) using one system clock.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (100 MHz clock gives 1 kHz per digit); minimum 2.
- MAX_DISPLAY, 9999: saturation ceiling for displayed value.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  reset, asynchronous, active-low
- waiting_to_start  input  1  timer idle/armed; show dashes
- show_result  input  1  result ready; rising edge captures time_elapsed
- time_elapsed  input  16  unsigned elapsed ms from timer
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, active-low; an[0] = ones digit
- bcd_valid  output  1  converted digits ready and displayed
- overflow  output  1  captured value exceeded MAX_DISPLAY

Behaviour:
- Reset (async, reset_n=0):
  - seg=7'h7F, dp=1, an=4'hF, bcd_valid=0, overflow=0.
  - FSM=IDLE; prescaler=0; digit index=0; BCD register=0.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1, free-running from reset.
  - At terminal count, the digit index advances 0→1→2→3→0.
  - seg/an/dp are registered: they update one cycle after an index change.
- FSM states:
  - IDLE: waits for a show_result rising edge (show_result=1 now, 0 the previous cycle). On the edge:
    - captures min(time_elapsed, MAX_DISPLAY) into the shift register;
    - sets overflow = (time_elapsed > MAX_DISPLAY);
    - clears BCD to 0 and bcd_valid to 0;
    - goes to CONVERT.
  - CONVERT: 16 cycles. Each cycle:
    - add 3 to every BCD nibble ≥5;
    - then shift {bcd,bin} left 1.
    - After the 16th shift, goes to SHOW.
  - SHOW: bcd_valid=1. Stays in SHOW while show_result=1. When show_result=0, goes to IDLE, clears bcd_valid and overflow.
- Latency: edge detected in cycle N; bcd_valid=1 in cycle N+17.
- Display selection, in priority order:
  1. SHOW: digit = BCD nibble[index].
  2. Else if waiting_to_start=1: dash on all digits (seg=7'b0111111).
  3. Else: blank (an=4'hF, seg=7'h7F).
- Segment codes, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- dp: 0 only when index=3, state=SHOW and overflow=1; otherwise 1.
- Boundaries:
  - show_result falls during CONVERT: abort to IDLE, bcd_valid stays 0, display blank or dashes.
  - A rising edge in SHOW cannot occur (show_result is already high). Re-capture requires show_result to fall, then rise again.
  - time_elapsed changes while in SHOW: ignored.
  - time_elapsed=0: displays 0000.
  - time_elapsed=9999: no overflow. 10000..65535: shows 9999, overflow=1.
  - Async reset mid-CONVERT or SHOW: immediate blank, all state cleared.

Optional Feature:
- LEADING_ZERO_BLANK_EN:
  - Defined: in SHOW, digits above the most significant nonzero digit are blanked (anode held high for that slot). The ones digit is always shown, so value 0 displays "   0".
  - Undefined: all four digits are always shown with leading zeros.
  - bcd_valid timing is identical in both builds.

Decomposition:
- Shared package reaction_pkg:
  - FSM state enum {IDLE, CONVERT, SHOW};
  - SEG_BLANK=7'h7F, SEG_DASH=7'b0111111;
  - digit-to-segment function;
  - MAX_DISPLAY_DEFAULT=9999.
- One sub-module, bin2bcd_serial:
  - start/done handshake;
  - 16-cycle double-dabble;
  - abort input.
- reaction_result_display owns the FSM, the scan prescaler and the segment mux.

Test Plan (SCAN_DIV=4):
- Reset, all inputs 0 → seg=7'h7F, an=4'hF, dp=1, bcd_valid=0 throughout.
- waiting_to_start=1 → an cycles 1110,1101,1011,0111, each held 4 cycles; seg=0111111 in every slot.
- time_elapsed=273, show_result rises at cycle N → bcd_valid=1 at N+17; nibbles {0,2,7,3}; digit 1 slot seg=1111000. With LEADING_ZERO_BLANK_EN, the index-3 slot keeps an=1111.
- time_elapsed=12345, show_result rises → digits 9999, overflow=1; dp=0 only in the index-3 slot.
- show_result rises, then falls 5 cycles later → FSM returns to IDLE, bcd_valid never asserts, display blank. A second rise with time_elapsed=0 shows 0000 after 17 cycles.
- reset_n pulsed low while in SHOW → outputs blank in the same cycle (asynchronous); bcd_valid=0 and overflow=0.
